// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, FIFO entry type and constants for the writeback arbiter.
package wb_pkg;

   localparam int DATA_W     = 32;
   localparam int ADDR_W     = 5;
   localparam int FIFO_DEPTH = 4;

   // Register r0 is hard-wired to zero; writes to it are dropped.
   localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

   // One pending mul/div result. valid is cleared when a younger ALU write
   // to the same register makes this value stale.
   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: pending mul/div results. Circular buffer with a per-entry squash
// by destination register and a youngest-valid-match search used for
// forwarding. Push and pop legality is the caller's responsibility.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic [ADDR_W-1:0]          push_reg_i,
   input  logic [DATA_W-1:0]          push_data_i,
   input  logic                       pop_i,
   input  logic                       squash_i,
   input  logic [ADDR_W-1:0]          squash_reg_i,
   input  logic [ADDR_W-1:0]          query_reg_i,
   output wb_entry_t                  head_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       query_hit_o,
   output logic [DATA_W-1:0]          query_data_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   wb_entry_t        mem_q [DEPTH];
   wb_entry_t        mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] idx_s;

   // Next state: squash matching entries, append the new entry, advance pointers.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (squash_i && (mem_q[i].rd == squash_reg_i)) begin
            mem_d[i].valid = 1'b0;
         end else begin
            mem_d[i].valid = mem_q[i].valid;
         end
      end
      // A same-cycle push to the squashed register is already stale.
      if (push_i) begin
         mem_d[wr_ptr_q].valid = !(squash_i && (push_reg_i == squash_reg_i));
         mem_d[wr_ptr_q].rd    = push_reg_i;
         mem_d[wr_ptr_q].data  = push_data_i;
         wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_i) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage and pointer registers; reset discards every queued entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Youngest-match search: scan oldest to youngest so the last hit wins.
   always_comb begin
      query_hit_o  = 1'b0;
      query_data_o = '0;
      idx_s        = rd_ptr_q;
      for (int i = 0; i < DEPTH; i++) begin
         idx_s = rd_ptr_q + PTR_W'(i);
         if ((CNT_W'(i) < count_q) && mem_q[idx_s].valid &&
             (mem_q[idx_s].rd == query_reg_i) && (query_reg_i != ZERO_REG)) begin
            query_hit_o  = 1'b1;
            query_data_o = mem_q[idx_s].data;
         end else begin
            query_hit_o  = query_hit_o;
            query_data_o = query_data_o;
         end
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: single register-file write port shared by the in-order ALU/load
// writeback (priority, never stalls) and the mul/div unit (queued in wb_fifo).
// The winning write is registered onto oRegWrite/oWriteReg/oWriteData.
// Build option: define WB_FORWARD_EN to build the forwarding query over
// pending writes; otherwise oQueryHit/oQueryData are tied to zero.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int FIFO_DEPTH = wb_pkg::FIFO_DEPTH
) (
   input  logic                          iCLK,
   input  logic                          iRST,
   input  logic                          iAluValid,
   input  logic [ADDR_W-1:0]             iAluReg,
   input  logic [DATA_W-1:0]             iAluData,
   input  logic                          iMdValid,
   input  logic [ADDR_W-1:0]             iMdReg,
   input  logic [DATA_W-1:0]             iMdData,
   output logic                          oMdReady,
   output logic                          oRegWrite,
   output logic [ADDR_W-1:0]             oWriteReg,
   output logic [DATA_W-1:0]             oWriteData,
   input  logic [ADDR_W-1:0]             iQueryReg,
   output logic                          oQueryHit,
   output logic [DATA_W-1:0]             oQueryData,
   output logic [$clog2(FIFO_DEPTH):0]   oPending
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic              alu_win_s;
   logic              md_ready_s;
   logic              push_s;
   logic              pop_s;
   wb_entry_t         head_s;
   logic [CNT_W-1:0]  count_s;
   logic              fifo_hit_s;
   logic [DATA_W-1:0] fifo_data_s;

   logic              reg_write_q, reg_write_d;
   logic [ADDR_W-1:0] write_reg_q, write_reg_d;
   logic [DATA_W-1:0] write_data_q, write_data_d;

   // ALU writes to r0 are idle cycles; they neither win nor squash.
   assign alu_win_s  = iAluValid && (iAluReg != ZERO_REG);
   // Readiness looks only at the registered count, never at a same-cycle pop.
   assign md_ready_s = !iRST && (count_s < CNT_W'(FIFO_DEPTH));
   // A handshake to r0 completes but stores nothing.
   assign push_s     = iMdValid && md_ready_s && (iMdReg != ZERO_REG);
   assign pop_s      = !alu_win_s && (count_s != '0);

   wb_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk          (iCLK),
      .rst          (iRST),
      .push_i       (push_s),
      .push_reg_i   (iMdReg),
      .push_data_i  (iMdData),
      .pop_i        (pop_s),
      .squash_i     (alu_win_s),
      .squash_reg_i (iAluReg),
      .query_reg_i  (iQueryReg),
      .head_o       (head_s),
      .count_o      (count_s),
      .query_hit_o  (fifo_hit_s),
      .query_data_o (fifo_data_s)
   );

   // Write-port select: ALU first, then FIFO head, else hold index/data.
   always_comb begin
      reg_write_d  = 1'b0;
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;
      if (alu_win_s) begin
         reg_write_d  = 1'b1;
         write_reg_d  = iAluReg;
         write_data_d = iAluData;
      end else if (pop_s) begin
         // A squashed head still drains, but without a write strobe.
         reg_write_d  = head_s.valid;
         write_reg_d  = head_s.rd;
         write_data_d = head_s.data;
      end else begin
         reg_write_d  = 1'b0;
      end
   end

   // Output write-port registers sampled by the register file on negedge.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         reg_write_q  <= 1'b0;
         write_reg_q  <= '0;
         write_data_q <= '0;
      end else begin
         reg_write_q  <= reg_write_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
      end
   end

   assign oMdReady   = md_ready_s;
   assign oRegWrite  = reg_write_q;
   assign oWriteReg  = write_reg_q;
   assign oWriteData = write_data_q;
   assign oPending   = count_s;

`ifdef WB_FORWARD_EN
   // Forwarding: youngest queued value first, then the in-flight output write.
   always_comb begin
      oQueryHit  = 1'b0;
      oQueryData = '0;
      if (iRST || (iQueryReg == ZERO_REG)) begin
         oQueryHit  = 1'b0;
         oQueryData = '0;
      end else if (fifo_hit_s) begin
         oQueryHit  = 1'b1;
         oQueryData = fifo_data_s;
      end else if (reg_write_q && (write_reg_q == iQueryReg)) begin
         oQueryHit  = 1'b1;
         oQueryData = write_data_q;
      end else begin
         oQueryHit  = 1'b0;
         oQueryData = '0;
      end
   end
`else
   logic unused_fwd_s;
   assign unused_fwd_s = ^{fifo_hit_s, fifo_data_s, iQueryReg};
   assign oQueryHit    = 1'b0;
   assign oQueryData   = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: scoreboard bench for wb_arbiter. A queue-based reference
// model predicts each cycle's write; a negedge monitor compares it.
module tb_wb_arbiter;

   localparam int DEPTH = 4;

   logic        iCLK = 1'b0;
   logic        iRST = 1'b1;
   logic        iAluValid = 1'b0;
   logic [4:0]  iAluReg = 5'd0;
   logic [31:0] iAluData = 32'd0;
   logic        iMdValid = 1'b0;
   logic [4:0]  iMdReg = 5'd0;
   logic [31:0] iMdData = 32'd0;
   logic [4:0]  iQueryReg = 5'd0;
   logic        oMdReady, oRegWrite, oQueryHit;
   logic [4:0]  oWriteReg;
   logic [31:0] oWriteData, oQueryData;
   logic [2:0]  oPending;

   typedef struct { bit v; logic [4:0] r; logic [31:0] d; } ent_t;
   typedef struct { bit we; logic [4:0] r; logic [31:0] d; int pend; } exp_t;

   ent_t        mq[$];
   exp_t        sbq[$];
   exp_t        mon_e;
   logic [31:0] rf [32];
   int          wr_cnt [32];
   int          n_checks = 0;
   int          n_errors = 0;

   wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
      .iCLK(iCLK), .iRST(iRST),
      .iAluValid(iAluValid), .iAluReg(iAluReg), .iAluData(iAluData),
      .iMdValid(iMdValid), .iMdReg(iMdReg), .iMdData(iMdData),
      .oMdReady(oMdReady), .oRegWrite(oRegWrite), .oWriteReg(oWriteReg),
      .oWriteData(oWriteData), .iQueryReg(iQueryReg), .oQueryHit(oQueryHit),
      .oQueryData(oQueryData), .oPending(oPending)
   );

   always #10 iCLK = ~iCLK;

   // Scoreboard monitor: compare the registered write against the model.
   always @(negedge iCLK) begin
      if (!iRST && sbq.size() > 0) begin
         mon_e = sbq.pop_front();
         n_checks++;
         if (oRegWrite !== mon_e.we) begin
            n_errors++;
            $display("FAIL sb_we: got %b expected %b at %0t", oRegWrite, mon_e.we, $time);
         end
         if (mon_e.we) begin
            n_checks++;
            if (oWriteReg !== mon_e.r || oWriteData !== mon_e.d) begin
               n_errors++;
               $display("FAIL sb_write: got r%0d=%h expected r%0d=%h at %0t",
                        oWriteReg, oWriteData, mon_e.r, mon_e.d, $time);
            end
         end
         n_checks++;
         if (oPending !== 3'(mon_e.pend)) begin
            n_errors++;
            $display("FAIL sb_pending: got %0d expected %0d at %0t", oPending, mon_e.pend, $time);
         end
         if (oRegWrite === 1'b1) begin
            rf[oWriteReg] = oWriteData;
            wr_cnt[oWriteReg]++;
         end
      end
   end

   // One clock of stimulus; the model predicts the next registered write.
   task automatic drive_cycle(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                              input bit mv, input logic [4:0] mr, input logic [31:0] md);
      exp_t e;
      ent_t h;
      bit   rdy, aw;
      @(negedge iCLK);
      #1;
      iAluValid = av; iAluReg = ar; iAluData = ad;
      iMdValid = mv;  iMdReg = mr;  iMdData = md;
      #1;
      rdy = (mq.size() < DEPTH);
      n_checks++;
      if (oMdReady !== rdy) begin
         n_errors++;
         $display("FAIL md_ready: got %b expected %b at %0t", oMdReady, rdy, $time);
      end
      aw = av && (ar != 5'd0);
      e.we = 1'b0; e.r = 5'd0; e.d = 32'd0;
      if (aw) begin
         for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].r == ar) mq[i].v = 1'b0;
         end
         e.we = 1'b1; e.r = ar; e.d = ad;
      end else if (mq.size() > 0) begin
         h = mq.pop_front();
         e.we = h.v; e.r = h.r; e.d = h.d;
      end
      if (mv && rdy && mr != 5'd0) begin
         h.v = !(aw && mr == ar); h.r = mr; h.d = md;
         mq.push_back(h);
      end
      e.pend = mq.size();
      sbq.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic do_reset(input logic [4:0] qr);
      @(negedge iCLK);
      #1;
      iRST = 1'b1;
      iAluValid = 1'b0; iMdValid = 1'b0; iQueryReg = qr;
      sbq.delete();
      mq.delete();
      #1;
      check_val("rst_query_hit", {31'd0, oQueryHit}, 32'd0);
      check_val("rst_md_ready", {31'd0, oMdReady}, 32'd0);
      @(negedge iCLK);
      #1;
      check_val("rst_pending", {29'd0, oPending}, 32'd0);
      check_val("rst_regwrite", {31'd0, oRegWrite}, 32'd0);
      check_val("rst_writereg", {27'd0, oWriteReg}, 32'd0);
      check_val("rst_writedata", oWriteData, 32'd0);
      iRST = 1'b0;
      #1;
      check_val("rst_release_ready", {31'd0, oMdReady}, 32'd1);
   endtask

   task automatic test_reset();
      do_reset(5'd0);
   endtask

   task automatic test_alu_write();
      drive_cycle(1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
      idle(1);
      check_val("alu_we", {31'd0, oRegWrite}, 32'd1);
      check_val("alu_reg", {27'd0, oWriteReg}, 32'd7);
      check_val("alu_data", oWriteData, 32'hDEADBEEF);
      idle(1);
      check_val("alu_idle_we", {31'd0, oRegWrite}, 32'd0);
      check_val("alu_hold_data", oWriteData, 32'hDEADBEEF);
   endtask

   task automatic test_fifo_full();
      for (int i = 0; i < 4; i++)
         drive_cycle(1'b1, 5'(16 + i), 32'h1000 + i, 1'b1, 5'(8 + i), 32'h800 + i);
      drive_cycle(1'b1, 5'd20, 32'h1004, 1'b1, 5'd12, 32'h0000000C);
      check_val("full_ready", {31'd0, oMdReady}, 32'd0);
      check_val("full_pending", {29'd0, oPending}, 32'd4);
      idle(6);
      check_val("drain_r8", rf[8], 32'h800);
      check_val("drain_r11", rf[11], 32'h803);
   endtask

   task automatic test_squash();
      int w5;
      w5 = wr_cnt[5];
      drive_cycle(1'b1, 5'd6, 32'h66, 1'b1, 5'd5, 32'h11);
      drive_cycle(1'b1, 5'd5, 32'h22, 1'b0, 5'd0, 32'd0);
      idle(2);
      check_val("squash_pop_we", {31'd0, oRegWrite}, 32'd0);
      check_val("squash_pending", {29'd0, oPending}, 32'd0);
      idle(1);
      check_val("squash_r5_writes", 32'(wr_cnt[5] - w5), 32'd1);
      check_val("squash_r5_value", rf[5], 32'h22);
   endtask

   task automatic test_r0();
      drive_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBAD);
      idle(1);
      check_val("r0_push_pending", {29'd0, oPending}, 32'd0);
      check_val("r0_push_we", {31'd0, oRegWrite}, 32'd0);
      drive_cycle(1'b1, 5'd6, 32'h61, 1'b1, 5'd9, 32'h99);
      drive_cycle(1'b1, 5'd0, 32'h5555, 1'b0, 5'd0, 32'd0);
      idle(1);
      check_val("r0_alu_pop_we", {31'd0, oRegWrite}, 32'd1);
      check_val("r0_alu_pop_reg", {27'd0, oWriteReg}, 32'd9);
      check_val("r0_alu_pop_data", oWriteData, 32'h99);
   endtask

   task automatic query(input string name, input logic [4:0] r, input bit eh, input logic [31:0] ed);
      iQueryReg = r;
      #1;
      n_checks++;
      if (oQueryHit !== eh || oQueryData !== ed) begin
         n_errors++;
         $display("FAIL %s: got hit=%b data=%h expected hit=%b data=%h",
                  name, oQueryHit, oQueryData, eh, ed);
      end
   endtask

   task automatic test_forward();
      drive_cycle(1'b1, 5'd20, 32'h20, 1'b1, 5'd3, 32'hA);
      drive_cycle(1'b1, 5'd20, 32'h20, 1'b1, 5'd3, 32'hB);
      drive_cycle(1'b1, 5'd20, 32'h20, 1'b0, 5'd0, 32'd0);
`ifdef WB_FORWARD_EN
      query("fwd_youngest", 5'd3, 1'b1, 32'hB);
      query("fwd_outreg", 5'd20, 1'b1, 32'h20);
`else
      query("fwd_off_r3", 5'd3, 1'b0, 32'd0);
      query("fwd_off_r20", 5'd20, 1'b0, 32'd0);
`endif
      query("fwd_r0", 5'd0, 1'b0, 32'd0);
      query("fwd_miss", 5'd4, 1'b0, 32'd0);
      idle(4);
      check_val("fwd_r3_final", rf[3], 32'hB);
   endtask

   task automatic test_reset_mid();
      drive_cycle(1'b1, 5'd21, 32'h21, 1'b1, 5'd12, 32'hC1);
      drive_cycle(1'b1, 5'd22, 32'h22, 1'b1, 5'd13, 32'hC2);
      drive_cycle(1'b1, 5'd23, 32'h23, 1'b1, 5'd14, 32'hC3);
      drive_cycle(1'b1, 5'd24, 32'h24, 1'b0, 5'd0, 32'd0);
      check_val("mid_pending", {29'd0, oPending}, 32'd3);
      do_reset(5'd13);
      idle(3);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 300; i++) begin
         drive_cycle($urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), $urandom,
                     $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom);
      end
      idle(6);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         rf[i] = 32'd0;
         wr_cnt[i] = 0;
      end
      test_reset();
      test_alu_write();
      test_fifo_full();
      test_squash();
      test_r0();
      test_forward();
      test_reset_mid();
      test_back_to_back();
      @(negedge iCLK);
      #1;
      check_val("sb_drained", 32'(sbq.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
